// File: rtl/pipelined_decode_ctrl.sv
// Registered MIPS decode stage: control bundle, load-use stalls, HI/LO occupancy and flush bubbles.
// Optional macro ILLEGAL_TRAP_EN adds the registered IllegalInstr pulse output.
package pipelined_decode_ctrl_pkg;

  localparam logic [5:0] ALU_NOP   = 6'd0;
  localparam logic [5:0] ALU_SLL   = 6'd1;
  localparam logic [5:0] ALU_SRL   = 6'd2;
  localparam logic [5:0] ALU_SRA   = 6'd3;
  localparam logic [5:0] ALU_SLLV  = 6'd4;
  localparam logic [5:0] ALU_SRLV  = 6'd5;
  localparam logic [5:0] ALU_SRAV  = 6'd6;
  localparam logic [5:0] ALU_JR    = 6'd7;
  localparam logic [5:0] ALU_JALR  = 6'd8;
  localparam logic [5:0] ALU_MTHI  = 6'd14;
  localparam logic [5:0] ALU_MTLO  = 6'd15;
  localparam logic [5:0] ALU_MFHI  = 6'd16;
  localparam logic [5:0] ALU_MFLO  = 6'd17;
  localparam logic [5:0] ALU_MULT  = 6'd19;
  localparam logic [5:0] ALU_MULTU = 6'd20;
  localparam logic [5:0] ALU_ADD   = 6'd21;
  localparam logic [5:0] ALU_ADDU  = 6'd22;
  localparam logic [5:0] ALU_SUB   = 6'd23;
  localparam logic [5:0] ALU_SUBU  = 6'd24;
  localparam logic [5:0] ALU_AND   = 6'd25;
  localparam logic [5:0] ALU_OR    = 6'd26;
  localparam logic [5:0] ALU_XOR   = 6'd27;
  localparam logic [5:0] ALU_NOR   = 6'd28;
  localparam logic [5:0] ALU_SLT   = 6'd29;
  localparam logic [5:0] ALU_SLTU  = 6'd30;
  localparam logic [5:0] ALU_MADD  = 6'd31;
  localparam logic [5:0] ALU_MSUB  = 6'd32;
  localparam logic [5:0] ALU_MUL   = 6'd33;
  localparam logic [5:0] ALU_BEQ   = 6'd36;
  localparam logic [5:0] ALU_BNE   = 6'd37;
  localparam logic [5:0] ALU_J     = 6'd38;
  localparam logic [5:0] ALU_JAL   = 6'd39;
  localparam logic [5:0] ALU_LB    = 6'd40;
  localparam logic [5:0] ALU_LH    = 6'd41;
  localparam logic [5:0] ALU_LW    = 6'd43;
  localparam logic [5:0] ALU_LBU   = 6'd44;
  localparam logic [5:0] ALU_LHU   = 6'd45;
  localparam logic [5:0] ALU_SB    = 6'd46;
  localparam logic [5:0] ALU_SH    = 6'd47;
  localparam logic [5:0] ALU_SW    = 6'd48;
  localparam logic [5:0] ALU_ADDI  = 6'd53;
  localparam logic [5:0] ALU_ADDIU = 6'd54;
  localparam logic [5:0] ALU_SLTI  = 6'd55;
  localparam logic [5:0] ALU_SLTIU = 6'd56;
  localparam logic [5:0] ALU_ANDI  = 6'd57;
  localparam logic [5:0] ALU_ORI   = 6'd58;
  localparam logic [5:0] ALU_XORI  = 6'd59;
  localparam logic [5:0] ALU_LUI   = 6'd60;

  // reg_dst: 00 rt, 01 rd, 10 $31. alu_src0: 00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 upper imm.
  // alu_src1: 00 rs, 01 shamt. mem_reg: 00 ALU, 01 memory, 10 link. mux_load/store: 00 word, 01 half, 10 byte.
  typedef struct packed {
    logic [5:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] alu_src0;
    logic [1:0] alu_src1;
    logic [1:0] mem_reg;
    logic [1:0] mux_load;
    logic [1:0] mux_store;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       jreg;
  } ctrl_t;

endpackage

module pipelined_decode_ctrl
  import pipelined_decode_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY    = 4,
  parameter int unsigned LOAD_USE_DEPTH = 1,
  parameter int unsigned REG_ADDR_W     = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           Instr,
  input  logic                  InstrValid,
  input  logic                  Flush,
  output logic [5:0]            ALUOp,
  output logic [1:0]            RegDst,
  output logic [1:0]            ALUSrc0,
  output logic [1:0]            ALUSrc1,
  output logic [1:0]            MemReg,
  output logic [1:0]            MuxLoad,
  output logic [1:0]            MuxStore,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  Branch,
  output logic                  JumpControl,
  output logic                  JRegControl,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  Stall,
  output logic                  MulBusy
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  IllegalInstr
`endif
);

  localparam int unsigned LU_W  = 2;
  localparam int unsigned MUL_W = 4;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] wr_dec;
  ctrl_t                 dec;
  ctrl_t                 ctrl_q;
  logic                  legal;
  logic                  rt_src;
  logic                  hilo_op;
  logic                  mul_op;
  logic                  lu_hit;
  logic                  lu_trig;
  logic                  mul_stall;
  logic                  issue;
  logic [LU_W-1:0]       lu_cnt;
  logic [LU_W-1:0]       lu_cnt_nxt;
  logic [MUL_W-1:0]      mul_cnt;
  logic [MUL_W-1:0]      mul_cnt_nxt;
  logic                  unused_shamt;

  assign opcode       = Instr[31:26];
  assign funct        = Instr[5:0];
  assign rs           = REG_ADDR_W'(Instr[25:21]);
  assign rt           = REG_ADDR_W'(Instr[20:16]);
  assign rd           = REG_ADDR_W'(Instr[15:11]);
  assign unused_shamt = ^Instr[10:6];

  // Instruction decode; any unrecognised encoding collapses to the all-zero bubble.
  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    rt_src  = 1'b0;
    hilo_op = 1'b0;
    mul_op  = 1'b0;
    case (opcode)
      6'h00: begin
        rt_src        = 1'b1;
        dec.reg_dst   = 2'b01;
        dec.reg_write = 1'b1;
        case (funct)
          6'h00: begin dec.alu_op = ALU_SLL; dec.alu_src1 = 2'b01; end
          6'h02: begin dec.alu_op = ALU_SRL; dec.alu_src1 = 2'b01; end
          6'h03: begin dec.alu_op = ALU_SRA; dec.alu_src1 = 2'b01; end
          6'h04: dec.alu_op = ALU_SLLV;
          6'h06: dec.alu_op = ALU_SRLV;
          6'h07: dec.alu_op = ALU_SRAV;
          6'h08: begin
            dec.alu_op    = ALU_JR;
            dec.reg_write = 1'b0;
            dec.jump      = 1'b1;
            dec.jreg      = 1'b1;
          end
          6'h09: begin
            dec.alu_op  = ALU_JALR;
            dec.mem_reg = 2'b10;
            dec.jump    = 1'b1;
            dec.jreg    = 1'b1;
          end
          6'h10: begin dec.alu_op = ALU_MFHI; hilo_op = 1'b1; end
          6'h11: begin dec.alu_op = ALU_MTHI; dec.reg_write = 1'b0; hilo_op = 1'b1; end
          6'h12: begin dec.alu_op = ALU_MFLO; hilo_op = 1'b1; end
          6'h13: begin dec.alu_op = ALU_MTLO; dec.reg_write = 1'b0; hilo_op = 1'b1; end
          6'h18, 6'h19: begin
            dec.alu_op    = (funct == 6'h18) ? ALU_MULT : ALU_MULTU;
            dec.reg_dst   = 2'b00;
            dec.reg_write = 1'b0;
            hilo_op       = 1'b1;
            mul_op        = 1'b1;
          end
          6'h20: dec.alu_op = ALU_ADD;
          6'h21: dec.alu_op = ALU_ADDU;
          6'h22: dec.alu_op = ALU_SUB;
          6'h23: dec.alu_op = ALU_SUBU;
          6'h24: dec.alu_op = ALU_AND;
          6'h25: dec.alu_op = ALU_OR;
          6'h26: dec.alu_op = ALU_XOR;
          6'h27: dec.alu_op = ALU_NOR;
          6'h2A: dec.alu_op = ALU_SLT;
          6'h2B: dec.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      6'h1C: begin
        rt_src  = 1'b1;
        hilo_op = 1'b1;
        mul_op  = 1'b1;
        case (funct)
          6'h00: dec.alu_op = ALU_MADD;
          6'h04: dec.alu_op = ALU_MSUB;
          6'h02: begin
            dec.alu_op    = ALU_MUL;
            dec.reg_dst   = 2'b01;
            dec.reg_write = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h02: begin dec.alu_op = ALU_J; dec.jump = 1'b1; end
      6'h03: begin
        dec.alu_op    = ALU_JAL;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'b10;
        dec.mem_reg   = 2'b10;
      end
      6'h04, 6'h05: begin
        dec.alu_op = (opcode == 6'h04) ? ALU_BEQ : ALU_BNE;
        dec.branch = 1'b1;
        rt_src     = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        dec.reg_write = 1'b1;
        dec.alu_src0  = 2'b01;
        case (opcode[1:0])
          2'b00:   dec.alu_op = ALU_ADDI;
          2'b01:   dec.alu_op = ALU_ADDIU;
          2'b10:   dec.alu_op = ALU_SLTI;
          default: dec.alu_op = ALU_SLTIU;
        endcase
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec.reg_write = 1'b1;
        dec.alu_src0  = 2'b10;
        case (opcode[1:0])
          2'b00:   dec.alu_op = ALU_ANDI;
          2'b01:   dec.alu_op = ALU_ORI;
          default: dec.alu_op = ALU_XORI;
        endcase
      end
      6'h0F: begin dec.alu_op = ALU_LUI; dec.reg_write = 1'b1; dec.alu_src0 = 2'b11; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src0  = 2'b01;
        dec.mem_reg   = 2'b01;
        case (opcode[2:0])
          3'b000:  begin dec.alu_op = ALU_LB;  dec.mux_load = 2'b10; end
          3'b001:  begin dec.alu_op = ALU_LH;  dec.mux_load = 2'b01; end
          3'b100:  begin dec.alu_op = ALU_LBU; dec.mux_load = 2'b10; end
          3'b101:  begin dec.alu_op = ALU_LHU; dec.mux_load = 2'b01; end
          default: dec.alu_op = ALU_LW;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.mem_write = 1'b1;
        dec.alu_src0  = 2'b01;
        rt_src        = 1'b1;
        case (opcode[1:0])
          2'b00:   begin dec.alu_op = ALU_SB; dec.mux_store = 2'b10; end
          2'b01:   begin dec.alu_op = ALU_SH; dec.mux_store = 2'b01; end
          default: dec.alu_op = ALU_SW;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec     = '0;
      rt_src  = 1'b0;
      hilo_op = 1'b0;
      mul_op  = 1'b0;
    end
  end

  always_comb begin
    case (dec.reg_dst)
      2'b01:   wr_dec = rd;
      2'b10:   wr_dec = REG_ADDR_W'(31);
      default: wr_dec = rt;
    endcase
  end

  // Hazard detection against the load sitting in ID/EX, plus HI/LO occupancy.
  assign lu_hit    = ctrl_q.mem_read && ctrl_q.reg_write && (WriteReg != '0) &&
                     ((WriteReg == rs) || (rt_src && (WriteReg == rt)));
  assign lu_trig   = InstrValid && legal && lu_hit;
  assign mul_stall = InstrValid && legal && hilo_op && MulBusy;
  assign Stall     = (lu_cnt != '0) || lu_trig || mul_stall;
  assign issue     = InstrValid && legal && !Flush && !Stall;

  always_comb begin
    lu_cnt_nxt = '0;
    if (Flush)                lu_cnt_nxt = '0;
    else if (lu_cnt != '0)    lu_cnt_nxt = lu_cnt - LU_W'(1);
    else if (lu_trig)         lu_cnt_nxt = LU_W'(LOAD_USE_DEPTH - 1);
  end

  always_comb begin
    mul_cnt_nxt = '0;
    if (issue && mul_op)      mul_cnt_nxt = MUL_W'(MUL_LATENCY);
    else if (mul_cnt != '0)   mul_cnt_nxt = mul_cnt - MUL_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q   <= '0;
      WriteReg <= '0;
      lu_cnt   <= '0;
      mul_cnt  <= '0;
      MulBusy  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      IllegalInstr <= 1'b0;
`endif
    end else begin
      ctrl_q   <= issue ? dec : '0;
      WriteReg <= issue ? wr_dec : '0;
      lu_cnt   <= lu_cnt_nxt;
      mul_cnt  <= mul_cnt_nxt;
      MulBusy  <= (mul_cnt_nxt != '0);
`ifdef ILLEGAL_TRAP_EN
      IllegalInstr <= InstrValid && !legal && !Flush && !Stall;
`endif
    end
  end

  assign ALUOp       = ctrl_q.alu_op;
  assign RegDst      = ctrl_q.reg_dst;
  assign ALUSrc0     = ctrl_q.alu_src0;
  assign ALUSrc1     = ctrl_q.alu_src1;
  assign MemReg      = ctrl_q.mem_reg;
  assign MuxLoad     = ctrl_q.mux_load;
  assign MuxStore    = ctrl_q.mux_store;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign RegWrite    = ctrl_q.reg_write;
  assign Branch      = ctrl_q.branch;
  assign JumpControl = ctrl_q.jump;
  assign JRegControl = ctrl_q.jreg;

endmodule

// File: doc/pipelined_decode_ctrl.md
Name: pipelined_decode_ctrl

Overview:
Registered successor to the combinational instruction decoder; it sits between the IF/ID and ID/EX pipeline registers.
- Decodes the 32-bit MIPS instruction into the team's standard control bundle and registers it (ID/EX control half).
- Adds load-use hazard stalling, a HI/LO multiply-occupancy counter, and flush/bubble insertion.
- Parametrised in stall depth, multiply latency and register-address width.

Parameters:
MUL_LATENCY, 4, cycles HI/LO stay busy after a mult-class issue (legal range 1..15)
LOAD_USE_DEPTH, 1, bubble cycles inserted on a load-use hazard (legal range 1..3)
REG_ADDR_W, 5, register-specifier width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Instr  in  32  instruction from IF/ID
InstrValid  in  1  Instr is meaningful this cycle
Flush  in  1  squash the instruction currently in decode (taken branch/jump)
ALUOp  out  6  team ALU operation code (nop=0, mflo=17, mult=19, add=21, lw=43, addi=53, ...), registered
RegDst, ALUSrc0, ALUSrc1, MemReg, MuxLoad, MuxStore  out  2 each  standard mux selects, registered
MemRead, MemWrite, RegWrite, Branch, JumpControl, JRegControl  out  1 each  standard strobes, registered
WriteReg  out  REG_ADDR_W  resolved destination (rt, rd or 31 per RegDst), registered
Stall  out  1  combinational; hold PC and IF/ID this cycle
MulBusy  out  1  registered; HI/LO occupancy counter nonzero

Behaviour:
- Reset (synchronous):
  - All registered outputs are 0 (the bubble).
  - Both counters are 0; Stall=0, MulBusy=0.
- Latency:
  - Decode is combinational from Instr.
  - Outputs update at the next rising Clk: 1-cycle latency.
- Bubble: every control output 0, ALUOp=0, WriteReg=0.
- Next-state priority: Reset > Flush > Stall > !InstrValid > normal decode.
  - Flush: bubble registered; load-use counter cleared; mul counter keeps counting.
  - Stall: bubble registered; Instr must be held by upstream.
  - !InstrValid: bubble, Stall=0.
  - Unrecognised encoding: bubble, Stall=0.
- Load-use hazard (Mealy, combinational Stall):
  - Trigger: the registered outputs show MemRead=1, RegWrite=1 and WriteReg!=0, and WriteReg equals the decoding instruction's rs, or its rt when rt is a source (R-type, store, beq/bne).
  - Effect: the LU counter loads LOAD_USE_DEPTH-1 and Stall=1 this cycle.
  - While the LU counter is nonzero, Stall=1 and the counter decrements each cycle.
  - The instruction issues normally once the counter reaches 0.
- HI/LO occupancy:
  - Issuing mult, multu, madd, msub or mul loads the MUL counter with MUL_LATENCY; MulBusy=1 while it is nonzero; it decrements each cycle.
  - While MulBusy=1, decoding mfhi, mflo, mthi, mtlo or another mult-class op forces Stall=1.
  - Such an op issues in the cycle MulBusy reads 0.
  - MUL_LATENCY=1: MulBusy pulses for exactly one cycle.
- Simultaneous hazards: Stall = LU stall OR MUL stall. Both counters run independently.
- Flush with Stall: Flush wins; Stall is still driven, so upstream holds, but the decode slot registers a bubble.
- Reset mid-stall: both counters clear; the next cycle decodes normally.
- Counters never wrap: decrement only when nonzero; saturate at 0.
- $0 destination:
  - WriteReg=0 never triggers a load-use hazard.
  - RegWrite is still reported as decoded.
- jal: WriteReg=31.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: adds output port IllegalInstr (out, 1, registered).
  - Pulses 1 for one cycle when a valid, unflushed, unstalled Instr fails to decode.
  - The bubble is still issued.
  - Reset value 0.
- Undefined: the port is absent and unrecognised encodings silently become bubbles.

Test Plan:
1. Reset held 2 cycles, then Instr=0x20080005 (addi $8,$0,5), InstrValid=1 -> next edge ALUOp=53, RegWrite=1, ALUSrc0=01, WriteReg=8, Stall=0.
2. Instr=0x8C080000 (lw $8,0($0)), then 0x01084820 (add $9,$8,$8) -> one cycle Stall=1 with a bubble registered (ALUOp=0); next cycle ALUOp=21, WriteReg=9.
3. Same as 2 with LOAD_USE_DEPTH=3 -> Stall=1 for exactly 3 cycles, 3 bubbles, then add issues.
4. 0x01090018 (mult $8,$9), then 0x00005012 (mflo $10), MUL_LATENCY=4 -> MulBusy=1 for 4 cycles; Stall=1 while MulBusy=1; ALUOp=17 with WriteReg=10 registered on the edge after MulBusy reads 0.
5. Load-use stall active and Flush=1 in the same cycle -> bubble registered, LU counter cleared, next cycle Stall=0 for a non-dependent instruction.
6. Instr=0xFC000000, InstrValid=1 -> bubble, Stall=0; IllegalInstr=1 for one cycle when ILLEGAL_TRAP_EN is defined.
